// File: rtl/fpu_issue_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fpnew_pkg (subset) / fpu_issue_queue                                        |
// | Request FIFO and issue stage feeding fpnew_top (FP32) with tag and          |
// | in-flight limiting.                                                         |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package fpnew_pkg;
    typedef enum logic [2:0] {
        FP32, FP64, FP16, FP8, FP16ALT
    } fp_format_e;

    typedef enum logic [3:0] {
        FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX, CMP, CLASSIFY,
        F2F, F2I, I2F, CPKAB, CPKCD
    } operation_e;

    typedef enum logic [2:0] {
        RNE = 3'b000, RTZ = 3'b001, RDN = 3'b010, RUP = 3'b011,
        RMM = 3'b100, ROD = 3'b101, DYN = 3'b111
    } roundmode_e;
endpackage

module fpu_issue_queue #(
    parameter int unsigned WIDTH           = 32,
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned TAG_WIDTH       = 3,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        flush_i,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  fpnew_pkg::operation_e       req_op_i,
    input  logic                        req_op_mod_i,
    input  fpnew_pkg::roundmode_e       req_rnd_i,
    input  logic [WIDTH-1:0]            req_a_i,
    input  logic [WIDTH-1:0]            req_b_i,
    output logic                        illegal_o,
    output logic [2:0][WIDTH-1:0]       fpu_operands_o,
    output fpnew_pkg::operation_e       fpu_op_o,
    output logic                        fpu_op_mod_o,
    output fpnew_pkg::roundmode_e       fpu_rnd_mode_o,
    output fpnew_pkg::fp_format_e       fpu_src_fmt_o,
    output fpnew_pkg::fp_format_e       fpu_dst_fmt_o,
    output logic [TAG_WIDTH-1:0]        fpu_tag_o,
    output logic                        fpu_valid_o,
    input  logic                        fpu_ready_i,
    input  logic                        fpu_out_valid_i,
    input  logic                        fpu_out_ready_i,
    output logic                        busy_o
);
    import fpnew_pkg::*;

    localparam int unsigned          c_ptr_w   = $clog2(DEPTH);
    localparam int unsigned          c_out_w   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [c_out_w-1:0]   c_max_out = c_out_w'(MAX_OUTSTANDING);

    typedef struct packed {
        operation_e       op;
        logic             mod;
        roundmode_e       rnd;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } entry_t;

    entry_t               r_mem [DEPTH];
    logic [c_ptr_w:0]     r_wptr;
    logic [c_ptr_w:0]     r_rptr;
    logic [c_out_w-1:0]   r_outst;
    logic [TAG_WIDTH-1:0] r_tag;
    logic                 r_illegal;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_legal;
    logic                 w_push;
    logic                 w_issue;
    logic                 w_comp;
    entry_t               w_head;

    assign w_full      = (r_wptr[c_ptr_w] != r_rptr[c_ptr_w]) &&
                         (r_wptr[c_ptr_w-1:0] == r_rptr[c_ptr_w-1:0]);
    assign w_empty     = (r_wptr == r_rptr);
    assign w_legal     = req_op_i inside {ADD, MUL, DIV, SQRT};
    assign req_ready_o = !w_full && !rst_i;
    // Flush discards every handshake of its own cycle.
    assign w_push      = req_valid_i && req_ready_o && w_legal && !flush_i;
    assign fpu_valid_o = !w_empty && (r_outst < c_max_out);
    assign w_issue     = fpu_valid_o && fpu_ready_i && !flush_i;
    assign w_comp      = fpu_out_valid_i && fpu_out_ready_i && (r_outst != '0);
    assign w_head      = r_mem[r_rptr[c_ptr_w-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wptr[c_ptr_w-1:0]] <= '{op: req_op_i, mod: req_op_mod_i,
                                           rnd: req_rnd_i, a: req_a_i, b: req_b_i};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_outst   <= '0;
            r_tag     <= '0;
            r_illegal <= 1'b0;
        end else if (flush_i) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_outst   <= '0;
            r_tag     <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= req_valid_i && req_ready_o && !w_legal;
            if (w_push) begin
                r_wptr <= r_wptr + (c_ptr_w + 1)'(1);
            end
            if (w_issue) begin
                r_rptr <= r_rptr + (c_ptr_w + 1)'(1);
                r_tag  <= r_tag + TAG_WIDTH'(1);
            end
            case ({w_issue, w_comp})
                2'b10:   r_outst <= r_outst + c_out_w'(1);
                2'b01:   r_outst <= r_outst - c_out_w'(1);
                default: r_outst <= r_outst;
            endcase
        end
    end

    // Slot layout follows fpnew: ADD uses slots 1/2, MUL/DIV 0/1, SQRT 0.
    always_comb begin
        fpu_operands_o = '0;
        case (w_head.op)
            ADD: begin
                fpu_operands_o[1] = w_head.a;
                fpu_operands_o[2] = w_head.b;
            end
            MUL, DIV: begin
                fpu_operands_o[0] = w_head.a;
                fpu_operands_o[1] = w_head.b;
            end
            SQRT: begin
                fpu_operands_o[0] = w_head.a;
            end
            default: begin
                fpu_operands_o = '0;
            end
        endcase
    end

    assign fpu_op_o       = w_head.op;
    assign fpu_op_mod_o   = w_head.mod;
    assign fpu_rnd_mode_o = w_head.rnd;
    assign fpu_src_fmt_o  = FP32;
    assign fpu_dst_fmt_o  = FP32;
    assign fpu_tag_o      = r_tag;
    assign illegal_o      = r_illegal;
    assign busy_o         = !w_empty || (r_outst != '0);

endmodule
`default_nettype wire
